fpu_register_file: RTL

- Register-file end of the register/FPU link: 32 x 32-bit FP registers, the FCSR (frm, sticky fflags) and the writeback path from the FPU and memory.
- Provides operand data and the resolved rounding mode to the FPU.
- Tracks one in-flight FPU operation and writes its result back when f_ready arrives.
- Sits between the control unit, the data memory port and the FPU/clock-counter.

---
 rtl/fpu_rf_pkg.sv | 28 ++
 rtl/fpu_fcsr.sv | 46 ++++
 rtl/fpu_register_file.sv | 122 ++++++++++++
 3 files changed

// File: rtl/fpu_rf_pkg.sv
// rtl/fpu_rf_pkg.sv - shared types and constants for the FP register file
package fpu_rf_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } fpu_rf_state_t;

    typedef struct packed {
        logic [2:0] frm;
        logic [4:0] fflags;
    } fcsr_t;

    localparam logic [2:0] FRM_RNE = 3'b000;
    localparam logic [2:0] FRM_DYN = 3'b111;

    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    // Rounding encodings 101, 110 and 111 are reserved once resolved
    function automatic logic frm_is_illegal(input logic [2:0] mode);
        return (mode == 3'b101) || (mode == 3'b110) || (mode == 3'b111);
    endfunction

endpackage

// File: rtl/fpu_fcsr.sv
// rtl/fpu_fcsr.sv - FCSR storage, sticky flag accumulation and dynamic rounding resolution
module fpu_fcsr
    import fpu_rf_pkg::*;
(
    input  logic       clk,
    input  logic       n_rst,
    input  logic       csr_we,
    input  logic [7:0] csr_wdata,
    input  logic       flag_we,
    input  logic [4:0] flags_in,
    input  logic [2:0] frm_in,
    output logic [2:0] frm,
    output logic [2:0] frm_csr,
    output logic [4:0] fflags,
    output logic       frm_illegal
);

    fcsr_t fcsr_q;
    fcsr_t fcsr_d;

    // Software write replaces the register; a completing op still ORs its flags on top
    always_comb begin
        fcsr_d = fcsr_q;
        if (csr_we) begin
            fcsr_d = fcsr_t'(csr_wdata);
        end
        if (flag_we) begin
            fcsr_d.fflags = fcsr_d.fflags | flags_in;
        end
    end

    // FCSR register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            fcsr_q <= '0;
        end else begin
            fcsr_q <= fcsr_d;
        end
    end

    assign frm         = (frm_in == FRM_DYN) ? fcsr_q.frm : frm_in;
    assign frm_illegal = frm_is_illegal(frm);
    assign frm_csr     = fcsr_q.frm;
    assign fflags      = fcsr_q.fflags;

endmodule

// File: rtl/fpu_register_file.sv
// rtl/fpu_register_file.sv - FP register array, FPU issue tracking and writeback
module fpu_register_file
    import fpu_rf_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NREG   = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic [ADDR_W-1:0] f_rs1,
    input  logic [ADDR_W-1:0] f_rs2,
    input  logic [ADDR_W-1:0] f_rd,
    input  logic              f_LW,
    input  logic              f_SW,
    input  logic              f_start,
    input  logic [2:0]        f_frm_in,
    input  logic [DATA_W-1:0] f_load_data,
    input  logic [DATA_W-1:0] FPU_out,
    input  logic [4:0]        f_flags,
    input  logic              f_ready,
    input  logic              csr_we,
    input  logic [7:0]        csr_wdata,
    output logic [DATA_W-1:0] f_rs1_data,
    output logic [DATA_W-1:0] f_rs2_data,
    output logic [DATA_W-1:0] f_store_data,
    output logic [2:0]        frm,
    output logic [2:0]        f_frm_out,
    output logic [4:0]        f_flags_out,
    output logic              frm_illegal,
    output logic              f_busy
);

    logic [DATA_W-1:0] regs [NREG];
    fpu_rf_state_t     state;
    logic [ADDR_W-1:0] pend_rd;
    logic              fpu_wb;

    // Only a result arriving while an op is outstanding is written back
    assign fpu_wb = (state == WAIT) && f_ready;
    assign f_busy = (state == WAIT) && !f_ready;

    // Issue tracking; a new op may be accepted in the same cycle the old one completes
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state   <= IDLE;
            pend_rd <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (f_start) begin
                        pend_rd <= f_rd;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (f_ready) begin
                        if (f_start) begin
                            pend_rd <= f_rd;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Register array writes; the load is issued later than the FPU op so it lands last
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (fpu_wb) begin
                regs[pend_rd] <= FPU_out;
            end
            if (f_LW) begin
                regs[f_rd] <= f_load_data;
            end
        end
    end

    // Operand 1 read with write-through bypass, load taking priority over writeback
    always_comb begin
        f_rs1_data = regs[f_rs1];
        if (f_LW && (f_rd == f_rs1)) begin
            f_rs1_data = f_load_data;
        end else if (fpu_wb && (pend_rd == f_rs1)) begin
            f_rs1_data = FPU_out;
        end
    end

    // Operand 2 read with the same bypass ordering
    always_comb begin
        f_rs2_data = regs[f_rs2];
        if (f_LW && (f_rd == f_rs2)) begin
            f_rs2_data = f_load_data;
        end else if (fpu_wb && (pend_rd == f_rs2)) begin
            f_rs2_data = FPU_out;
        end
    end

    assign f_store_data = f_SW ? f_rs2_data : '0;

    fpu_fcsr u_fcsr (
        .clk         (clk),
        .n_rst       (n_rst),
        .csr_we      (csr_we),
        .csr_wdata   (csr_wdata),
        .flag_we     (fpu_wb),
        .flags_in    (f_flags),
        .frm_in      (f_frm_in),
        .frm         (frm),
        .frm_csr     (f_frm_out),
        .fflags      (f_flags_out),
        .frm_illegal (frm_illegal)
    );

endmodule
